tx_frame_arbiter: RTL and testbench
===================================

TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 Parameter IFG_CYCLES, default 12, idle cycles inserted after each forwarded frame (0 = none).
REQ-002 Parameter MAX_FRAME_LEN, default 1518, beat count above which a frame is flagged oversize.
REQ-003 gtx_tclk_i  in  1  clock; the block uses no other clock.
REQ-004 gtx_tresetn_i  in  1  reset, asynchronous, active-high.
REQ-005 s0_axis_tdata/tvalid/tlast  in  8/1/1  command-response byte stream (requester 0).
REQ-006 s0_axis_tready  out  1  ready to requester 0.
REQ-007 s1_axis_tdata/tvalid/tlast  in  8/1/1  ADC-data byte stream (requester 1).
REQ-008 s1_axis_tready  out  1  ready to requester 1.
REQ-009 m_axis_tdata/tvalid/tlast  out  8/1/1  merged stream to the Ethernet MAC TX.
REQ-010 m_axis_tready  in  1  MAC TX ready.
REQ-011 cfg_strict_pri_i  in  1  1 = requester 0 strict priority; 0 = round-robin.
REQ-012 grant_o  out  2  one-hot current owner; 00 when no owner.
REQ-013 frame_cnt0_o, frame_cnt1_o  out  16 each  completed frames per requester.
REQ-014 oversize_o  out  1  one-cycle pulse on oversize detection.

Function
REQ-015 The FSM SHALL have states IDLE, PASS0, PASS1 and GAP.
REQ-016 In IDLE with neither tvalid high, the FSM SHALL stay in IDLE.
REQ-017 In IDLE with exactly one sN_axis_tvalid high, the FSM SHALL enter PASSN on the next edge.
REQ-018 With both high and cfg_strict_pri_i=1, the FSM SHALL enter PASS0.
REQ-019 With both high and cfg_strict_pri_i=0, the FSM SHALL enter the PASS state of the requester not in last_grant; last_grant resets to 1, so requester 0 wins the first tie.
REQ-020 last_grant SHALL update on entry to PASS0/PASS1.
REQ-021 In PASSN, m_axis_tdata/tvalid/tlast SHALL equal sN's inputs combinationally (zero latency).
REQ-022 In PASSN, sN_axis_tready SHALL equal m_axis_tready; the other requester's tready SHALL be 0.
REQ-023 Outside PASS states, m_axis_tvalid and both s*_tready SHALL be 0.
REQ-024 Arbitration SHALL occur only at frame boundaries; a grant is held until a beat with tvalid, tready and tlast all high.
REQ-025 On that final beat, the FSM SHALL go to GAP if IFG_CYCLES>0, otherwise directly to IDLE.
REQ-026 In GAP, a counter SHALL run for exactly IFG_CYCLES cycles, then the FSM returns to IDLE.
REQ-027 Total grant overhead SHALL be 1 cycle (IDLE decision) plus IFG_CYCLES between back-to-back frames.
REQ-028 A 16-bit beat counter SHALL count accepted beats of the current frame, cleared on grant.
REQ-029 When the beat counter reaches MAX_FRAME_LEN without tlast, oversize_o SHALL pulse once per frame.
REQ-030 After oversize, forwarding SHALL continue unchanged; the beat counter SHALL saturate.
REQ-031 frameN_cnt SHALL increment by 1 on each last beat forwarded from requester N and wrap 0xFFFF->0x0000.
REQ-032 Stalls (m_axis_tready=0) and source bubbles (tvalid=0) within a frame SHALL NOT release the grant.
REQ-033 grant_o SHALL be 01 in PASS0, 10 in PASS1 and 00 otherwise.

Reset
REQ-034 On gtx_tresetn_i=1 the block SHALL asynchronously enter IDLE, with last_grant=1 and all counters, grant_o, oversize_o and s*/m tready/tvalid equal to 0.
REQ-035 A reset mid-frame SHALL abandon the frame with no tlast emitted; after release, the next frame is arbitrated fresh.

Structure
REQ-036 State encodings and the default IFG/MAX_FRAME_LEN constants SHALL live in shared package tx_arb_pkg.
REQ-037 The block SHALL be a single module with no sub-modules; the round-robin selector SHALL be inline.

Verification
REQ-038 Test: only s0 sends a 64-beat frame with m_tready=1 -> 64 beats appear unchanged on m; tlast on beat 64; grant_o=01; frame_cnt0=1; 12 idle cycles follow.
REQ-039 Test: both requesters continuously valid, cfg_strict_pri_i=0 -> frames alternate 0,1,0,1; frames never interleave; counters equal after 4 frames (2/2).
REQ-040 Test: both requesters continuously valid, cfg_strict_pri_i=1 -> only s0 is served; frame_cnt1 stays 0.
REQ-041 Test: m_axis_tready toggles 1-0-1 every cycle mid-frame -> no byte is lost or duplicated; grant is held throughout.
REQ-042 Test: 1600-beat frame without early tlast, MAX_FRAME_LEN=1518 -> oversize_o pulses once, at beat 1518; all 1600 beats are forwarded.
REQ-043 Test: reset asserted at beat 10 of a frame -> outputs go to 0 immediately; after release, the next frame from s1 is granted cleanly.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// Shared types and defaults for the two-source Ethernet TX frame arbiter.
// Holds the FSM state encoding and the default gap/oversize constants.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  localparam int IFG_CYCLES_DEF    = 12;
  localparam int MAX_FRAME_LEN_DEF = 1518;

endpackage

// File: rtl/tx_frame_arbiter.sv
// Frame-level arbiter merging two AXI-Stream byte sources into MAC TX.
// Ports: s0/s1 slave streams, m master stream, cfg_strict_pri_i, grant_o,
// frame_cnt0_o/frame_cnt1_o, oversize_o; gtx_tclk_i, gtx_tresetn_i (act-high).
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int IFG_CYCLES    = IFG_CYCLES_DEF,
  parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_DEF
) (
  input  logic        gtx_tclk_i,
  input  logic        gtx_tresetn_i,
  input  logic [7:0]  s0_axis_tdata,
  input  logic        s0_axis_tvalid,
  input  logic        s0_axis_tlast,
  output logic        s0_axis_tready,
  input  logic [7:0]  s1_axis_tdata,
  input  logic        s1_axis_tvalid,
  input  logic        s1_axis_tlast,
  output logic        s1_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  input  logic        cfg_strict_pri_i,
  output logic [1:0]  grant_o,
  output logic [15:0] frame_cnt0_o,
  output logic [15:0] frame_cnt1_o,
  output logic        oversize_o
);

  localparam logic [15:0] LP_MAX      = 16'(MAX_FRAME_LEN);
  localparam logic [15:0] LP_IFG_LAST = 16'(IFG_CYCLES - 1);
  localparam bit          LP_HAS_GAP  = (IFG_CYCLES > 0);

  arb_state_e  r_state;
  logic        r_last_grant;
  logic [1:0]  r_grant;
  logic [15:0] r_beat_cnt;
  logic [15:0] r_ifg_cnt;
  logic [15:0] r_frame_cnt0;
  logic [15:0] r_frame_cnt1;
  logic        r_oversize;

  logic w_pass0;
  logic w_pass1;
  logic w_sel0;
  logic w_sel1;
  logic w_acc;
  logic w_end;

  assign w_pass0 = (r_state == ST_PASS0);
  assign w_pass1 = (r_state == ST_PASS1);

  // 0 wins when alone, under strict priority, or when 1 was served last.
  assign w_sel0 = s0_axis_tvalid &
                  (~s1_axis_tvalid | cfg_strict_pri_i | r_last_grant);
  assign w_sel1 = s1_axis_tvalid & ~w_sel0;

  always_comb begin
    m_axis_tdata   = 8'h00;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    unique case (1'b1)
      w_pass0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
      end
      w_pass1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign w_acc = m_axis_tvalid & m_axis_tready;
  assign w_end = w_acc & m_axis_tlast;

  always_ff @(posedge gtx_tclk_i or posedge gtx_tresetn_i) begin
    if (gtx_tresetn_i) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 2'b00;
      r_beat_cnt   <= '0;
      r_ifg_cnt    <= '0;
      r_frame_cnt0 <= '0;
      r_frame_cnt1 <= '0;
      r_oversize   <= 1'b0;
    end else begin
      r_oversize <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_beat_cnt <= '0;
          if (w_sel0) begin
            r_state      <= ST_PASS0;
            r_grant      <= 2'b01;
            r_last_grant <= 1'b0;
          end else if (w_sel1) begin
            r_state      <= ST_PASS1;
            r_grant      <= 2'b10;
            r_last_grant <= 1'b1;
          end
        end
        ST_PASS0, ST_PASS1: begin
          if (w_acc) begin
            // Saturate so the oversize pulse fires once per frame.
            if (r_beat_cnt != LP_MAX)
              r_beat_cnt <= r_beat_cnt + 16'd1;
            if (!m_axis_tlast && r_beat_cnt == LP_MAX - 16'd1)
              r_oversize <= 1'b1;
          end
          if (w_end) begin
            if (w_pass0)
              r_frame_cnt0 <= r_frame_cnt0 + 16'd1;
            else
              r_frame_cnt1 <= r_frame_cnt1 + 16'd1;
            r_grant   <= 2'b00;
            r_ifg_cnt <= '0;
            r_state   <= LP_HAS_GAP ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (r_ifg_cnt == LP_IFG_LAST)
            r_state <= ST_IDLE;
          else
            r_ifg_cnt <= r_ifg_cnt + 16'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_o      = r_grant;
  assign frame_cnt0_o = r_frame_cnt0;
  assign frame_cnt1_o = r_frame_cnt1;
  assign oversize_o   = r_oversize;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter: table vectors, directed
// corner sequences and randomized traffic against a frame-level model.
module tb_tx_frame_arbiter;

  localparam int IFG  = 12;
  localparam int MAXL = 1518;

  typedef struct packed {
    logic       strict;
    logic       v0;
    logic       v1;
    logic [1:0] grant;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s0_tdata, s1_tdata, m_tdata;
  logic        s0_tvalid, s0_tlast, s0_tready;
  logic        s1_tvalid, s1_tlast, s1_tready;
  logic        m_tvalid, m_tlast, m_tready;
  logic        strict;
  logic [1:0]  grant;
  logic [15:0] fc0, fc1;
  logic        ov;

  tx_frame_arbiter #(
    .IFG_CYCLES(IFG),
    .MAX_FRAME_LEN(MAXL)
  ) dut (
    .gtx_tclk_i(clk),
    .gtx_tresetn_i(rst),
    .s0_axis_tdata(s0_tdata),
    .s0_axis_tvalid(s0_tvalid),
    .s0_axis_tlast(s0_tlast),
    .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata),
    .s1_axis_tvalid(s1_tvalid),
    .s1_axis_tlast(s1_tlast),
    .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .cfg_strict_pri_i(strict),
    .grant_o(grant),
    .frame_cnt0_o(fc0),
    .frame_cnt1_o(fc1),
    .oversize_o(ov)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [8:0] q0[$], q1[$], e0[$], e1[$];
  logic       h0, h1;
  int         bub, rmode;
  logic [15:0] fcm0, fcm1;
  int         zero_run, beats, n_out, n_frames, n_ov, ov_beat, n_last_at;
  logic       frame_open, own, m_last, exp_ov, exp_nv;
  logic [1:0] exp_next, prev_grant, g_seen;
  int         order[$];
  vec_t       tbl[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    n_out = 0; n_frames = 0; n_ov = 0; ov_beat = 0; n_last_at = 0;
    g_seen = 2'b00;
    order.delete();
  endtask

  task automatic reset_model();
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    h0 = 1'b0; h1 = 1'b0;
    s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = 8'h00;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = 8'h00;
    fcm0 = 16'd0; fcm1 = 16'd0;
    zero_run = 1000; beats = 0;
    frame_open = 1'b0; own = 1'b0; m_last = 1'b1;
    exp_ov = 1'b0; exp_nv = 1'b0; exp_next = 2'b00; prev_grant = 2'b00;
    clear_stats();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    reset_model();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic push_frame(input bit n, input int len);
    logic [8:0] w;
    for (int i = 0; i < len; i++) begin
      w[7:0] = 8'($urandom);
      w[8]   = (i == len - 1);
      if (n) begin q1.push_back(w); e1.push_back(w); end
      else   begin q0.push_back(w); e0.push_back(w); end
    end
  endtask

  task automatic drive();
    logic [8:0] w;
    if (!h0) s0_tvalid = (q0.size() > 0) && ($urandom_range(0, 99) >= 32'(bub));
    w = (q0.size() > 0) ? q0[0] : 9'h000;
    {s0_tlast, s0_tdata} = w;
    if (!h1) s1_tvalid = (q1.size() > 0) && ($urandom_range(0, 99) >= 32'(bub));
    w = (q1.size() > 0) ? q1[0] : 9'h000;
    {s1_tlast, s1_tdata} = w;
    case (rmode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check_cycle();
    logic [8:0] b;
    if (exp_nv) chk("arb_grant", grant, exp_next);
    exp_nv = 1'b0;
    chk("oversize", ov, exp_ov);
    exp_ov = 1'b0;
    chk("frame_cnt0", fc0, fcm0);
    chk("frame_cnt1", fc1, fcm1);
    if (frame_open) chk("grant_hold", grant, own ? 2'b10 : 2'b01);
    if (ov) begin n_ov++; ov_beat = beats; end
    if (grant == 2'b01) begin
      chk("pass0", {m_tvalid, m_tlast, m_tdata}, {s0_tvalid, s0_tlast, s0_tdata});
      chk("tready0", {s0_tready, s1_tready}, {m_tready, 1'b0});
    end else if (grant == 2'b10) begin
      chk("pass1", {m_tvalid, m_tlast, m_tdata}, {s1_tvalid, s1_tlast, s1_tdata});
      chk("tready1", {s0_tready, s1_tready}, {1'b0, m_tready});
    end else begin
      chk("grant_legal", grant, 2'b00);
      chk("idle_out", {m_tvalid, s0_tready, s1_tready}, 3'b000);
    end
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      chk("ifg_len", 32'(zero_run >= IFG + 1), 1);
      m_last = grant[1];
      own = grant[1];
      frame_open = 1'b1;
    end
    if (grant == 2'b00) zero_run++;
    if (m_tvalid && m_tready && (grant == 2'b01 || grant == 2'b10)) begin
      g_seen = g_seen | grant;
      if (grant[1] ? (e1.size() == 0) : (e0.size() == 0)) begin
        chk("spurious_beat", grant[1] ? e1.size() : e0.size(), 1);
      end else begin
        b = grant[1] ? e1.pop_front() : e0.pop_front();
        chk("beat_data", {m_tlast, m_tdata}, b);
      end
      n_out++; beats++;
      if (m_tlast) begin
        if (grant[1]) fcm1 = fcm1 + 16'd1;
        else          fcm0 = fcm0 + 16'd1;
        order.push_back(int'(grant[1]));
        n_frames++; n_last_at = n_out;
        beats = 0; zero_run = 0; frame_open = 1'b0;
      end else if (beats == MAXL) begin
        exp_ov = 1'b1;
      end
    end
    if (grant == 2'b00 && zero_run >= IFG + 1) begin
      exp_nv = 1'b1;
      if (s0_tvalid && s1_tvalid) exp_next = (strict || m_last) ? 2'b01 : 2'b10;
      else if (s0_tvalid)         exp_next = 2'b01;
      else if (s1_tvalid)         exp_next = 2'b10;
      else                        exp_next = 2'b00;
    end
    prev_grant = grant;
  endtask

  task automatic pops();
    logic [8:0] t;
    if (s0_tvalid && s0_tready && q0.size() > 0) t = q0.pop_front();
    if (s1_tvalid && s1_tready && q1.size() > 0) t = q1.pop_front();
    h0 = s0_tvalid && !s0_tready;
    h1 = s1_tvalid && !s1_tready;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    drive();
    #4;
    check_cycle();
    pops();
  endtask

  task automatic run_frames(input int target, input int budget, input string nm);
    int k = 0;
    while (n_frames < target && k < budget) begin cycle(); k++; end
    if (n_frames < target) chk({nm, "_timeout"}, n_frames, target);
  endtask

  task automatic run_idle(input int budget);
    int   k = 0;
    logic done = 1'b0;
    while (!done && k < budget) begin
      cycle(); k++;
      done = (q0.size() == 0) && (q1.size() == 0) && !frame_open &&
             (zero_run >= IFG + 1);
    end
    chk("idle_timeout", done, 1);
  endtask

  initial begin
    int k;
    rst = 1'b1; strict = 1'b0; m_tready = 1'b1; rmode = 0; bub = 0;
    reset_model();

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'b00};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'b01};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'b10};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'b10};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'b01};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'b01};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'b10};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 2'b10};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'b01};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'b01};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2'b10};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 2'b01};

    do_reset();
    #1;
    chk("reset_state", {grant, fc0, fc1, ov, m_tvalid, s0_tready, s1_tready}, 0);

    // Arbitration table: the loser's pending frame is withdrawn each time.
    for (int i = 0; i < 12; i++) begin
      strict = tbl[i].strict;
      if (tbl[i].v0) push_frame(0, 1);
      if (tbl[i].v1) push_frame(1, 1);
      if (tbl[i].grant == 2'b00) begin
        repeat (IFG + 3) cycle();
        chk($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
      end else begin
        k = 0;
        while (grant == 2'b00 && k < 40) begin cycle(); k++; end
        chk($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
        if (tbl[i].grant == 2'b01) begin q1.delete(); e1.delete(); h1 = 1'b0; end
        else                       begin q0.delete(); e0.delete(); h0 = 1'b0; end
        run_idle(100);
      end
    end

    // Single 64-beat frame from s0.
    do_reset(); strict = 1'b0; rmode = 0; bub = 0;
    push_frame(0, 64);
    run_frames(1, 300, "t64");
    chk("t64_beats", n_out, 64);
    chk("t64_tlast_at", n_last_at, 64);
    chk("t64_grant", g_seen, 2'b01);
    for (int i = 0; i < IFG; i++) begin
      cycle();
      chk("t64_ifg", {grant, m_tvalid}, 3'b000);
    end
    chk("t64_cnt0", fc0, 1);

    // Round-robin with both sources continuously valid.
    do_reset(); strict = 1'b0;
    for (int i = 0; i < 2; i++) begin push_frame(0, 6); push_frame(1, 6); end
    run_frames(4, 400, "rr");
    chk("rr_nframes", order.size(), 4);
    for (int i = 0; i < order.size(); i++) chk("rr_order", order[i], i % 2);
    cycle();
    chk("rr_cnt", {fc0, fc1}, {16'd2, 16'd2});

    // Strict priority starves s1 while s0 has frames.
    do_reset(); strict = 1'b1;
    for (int i = 0; i < 3; i++) push_frame(0, 5);
    push_frame(1, 5);
    run_frames(3, 400, "sp");
    chk("sp_nframes", order.size(), 3);
    for (int i = 0; i < order.size(); i++) chk("sp_order", order[i], 0);
    cycle();
    chk("sp_cnt", {fc0, fc1}, {16'd3, 16'd0});
    run_idle(200);

    // Ready toggling every cycle mid-frame.
    do_reset(); strict = 1'b0; rmode = 1;
    push_frame(0, 24);
    run_frames(1, 300, "tog");
    chk("tog_beats", n_out, 24);
    chk("tog_left", e0.size(), 0);
    chk("tog_grant", g_seen, 2'b01);
    rmode = 0;

    // Oversize frame.
    do_reset();
    push_frame(0, 1600);
    run_frames(1, 2000, "ovs");
    chk("ovs_pulses", n_ov, 1);
    chk("ovs_at_beat", ov_beat, MAXL);
    chk("ovs_beats", n_out, 1600);

    // Reset in the middle of a frame.
    do_reset();
    push_frame(0, 30);
    k = 0;
    while (n_out < 10 && k < 100) begin cycle(); k++; end
    chk("rst_pre_beats", n_out, 10);
    @(posedge clk); #1;
    drive();
    #1 rst = 1'b1;
    #1;
    chk("rst_out", {m_tvalid, m_tlast, s0_tready, s1_tready, grant, ov}, 0);
    chk("rst_cnt", {fc0, fc1}, 0);
    reset_model();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    push_frame(1, 8);
    run_frames(1, 100, "rst_s1");
    chk("rst_s1_grant", g_seen, 2'b10);
    chk("rst_s1_beats", n_out, 8);
    cycle();
    chk("rst_s1_cnt", {fc0, fc1}, {16'd0, 16'd1});

    // Randomized traffic.
    do_reset();
    for (int b = 0; b < 40; b++) begin
      strict = 1'($urandom_range(0, 1));
      rmode  = int'($urandom_range(0, 2));
      bub    = int'($urandom_range(0, 40));
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        push_frame(0, int'($urandom_range(1, 30)));
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        push_frame(1, int'($urandom_range(1, 30)));
      run_idle(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
